// File: rtl/stack_pkg.sv
// stack_pkg: shared state encoding, requester IDs and default sizing for the
// shared LIFO stack controller.
package stack_pkg;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_DW    = 8;
   localparam logic RID0 = 1'b0;
   localparam logic RID1 = 1'b1;
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_MID   = 2'd1,
      S_FULL  = 2'd2
   } state_t;
endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x DW register array, synchronous write, combinational read.
// Contents are deliberately not reset.
module stack_mem #(
   parameter int DEPTH = 4,
   parameter int DW    = 8,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbiter sharing one LIFO stack between two
// requesters; owns the stack pointer, storage access and error pulses.
module stack_arbiter
   import stack_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int DW    = DEF_DW,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_push,
   input  logic          r0_pop,
   input  logic [DW-1:0] r0_wdata,
   input  logic          r1_push,
   input  logic          r1_pop,
   input  logic [DW-1:0] r1_wdata,
   output logic          gnt0,
   output logic          gnt1,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          rid,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          ovf,
   output logic          udf
);
   localparam logic [AW:0] ONE  = (AW+1)'(1);
   localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW:0]   sp_q, sp_d, count_q, count_d;
   logic [DW-1:0] rdata_q, rdata_d, wdata, mem_rdata;
   logic          rvalid_q, rvalid_d, rid_q, rid_d, ovf_q, ovf_d, udf_q, udf_d;
   logic          last_gnt_q, last_gnt_d;
   logic          v0, v1, push, pop, wr, rd;

   // Holding both push and pop makes a requester ineligible rather than picking one.
   assign v0    = r0_push ^ r0_pop;
   assign v1    = r1_push ^ r1_pop;
   assign gnt0  = v0 & (~v1 | last_gnt_q == RID1);
   assign gnt1  = v1 & (~v0 | last_gnt_q == RID0);
   assign push  = (gnt0 & r0_push) | (gnt1 & r1_push);
   assign pop   = (gnt0 & r0_pop) | (gnt1 & r1_pop);
   assign wdata = gnt1 ? r1_wdata : r0_wdata;
   assign full  = state_q == S_FULL;
   assign empty = state_q == S_EMPTY;
   assign wr    = push & ~full;
   assign rd    = pop & ~empty;

   stack_mem #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (wr),
      .waddr (sp_q[AW-1:0]),
      .wdata (wdata),
      .raddr (AW'(sp_q - ONE)),
      .rdata (mem_rdata)
   );

   always_comb begin
      sp_d       = wr ? sp_q + ONE : rd ? sp_q - ONE : sp_q;
      count_d    = wr ? count_q + ONE : rd ? count_q - ONE : count_q;
      state_d    = (state_q == S_EMPTY && wr)                  ? S_MID   :
                   (state_q == S_MID && wr && count_q == LAST) ? S_FULL  :
                   (state_q == S_MID && rd && count_q == ONE)  ? S_EMPTY :
                   (state_q == S_FULL && rd)                   ? S_MID   : state_q;
      rdata_d    = rd ? mem_rdata : rdata_q;
      rvalid_d   = rd;
      rid_d      = rd ? (gnt1 ? RID1 : RID0) : rid_q;
      ovf_d      = push & full;
      udf_d      = pop & empty;
      last_gnt_d = gnt0 ? RID0 : gnt1 ? RID1 : last_gnt_q;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= S_EMPTY;
         sp_q       <= '0;
         count_q    <= '0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         rid_q      <= RID0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         last_gnt_q <= RID1;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         count_q    <= count_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         rid_q      <= rid_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         last_gnt_q <= last_gnt_d;
      end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign rid    = rid_q;
   assign count  = count_q;
   assign ovf    = ovf_q;
   assign udf    = udf_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: table-driven vectors for grants/occupancy/errors, with a
// pop-data scoreboard fed from a reference stack model.
module tb_stack_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       r0_push, r0_pop, r1_push, r1_pop;
   logic [7:0] r0_wdata, r1_wdata;
   logic       gnt0, gnt1, rvalid, rid, full, empty, ovf, udf;
   logic [7:0] rdata;
   logic [2:0] count;

   always #5 clk = ~clk;

   stack_arbiter #(.DEPTH(4), .DW(8), .AW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_push(r0_push), .r0_pop(r0_pop), .r0_wdata(r0_wdata),
      .r1_push(r1_push), .r1_pop(r1_pop), .r1_wdata(r1_wdata),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .rvalid(rvalid), .rid(rid),
      .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
   );

   typedef struct {
      logic p0, q0; logic [7:0] d0;
      logic p1, q1; logic [7:0] d1;
      logic g0, g1; int cnt; logic ovf, udf;
   } vec_t;
   typedef struct packed {logic [7:0] d; logic id;} exp_t;

   int checks = 0, failures = 0;
   vec_t vecs[$];
   logic [7:0] model[$];
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic p0, q0, input logic [7:0] d0,
                               input logic p1, q1, input logic [7:0] d1,
                               input logic g0, g1, input int cnt, input logic o, u);
      vec_t v;
      v.p0 = p0; v.q0 = q0; v.d0 = d0; v.p1 = p1; v.q1 = q1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.cnt = cnt; v.ovf = o; v.udf = u;
      return v;
   endfunction

   task automatic check_rdata(input string tag);
      exp_t e;
      if (rvalid) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s unexpected rvalid rdata=%0h", tag, rdata);
         end else begin
            e = exp_q.pop_front();
            chk({tag, " rdata"}, 32'(rdata), 32'(e.d));
            chk({tag, " rid"}, 32'(rid), 32'(e.id));
         end
      end else if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++; failures++;
         $display("FAIL %s missing rvalid expected rdata=%0h", tag, e.d);
      end
   endtask

   // Called at posedge+1; leaves the bench at the following posedge+1.
   task automatic step(input vec_t v, input int i);
      string tag;
      logic is_push, is_pop;
      tag = $sformatf("vec%0d", i);
      r0_push = v.p0; r0_pop = v.q0; r0_wdata = v.d0;
      r1_push = v.p1; r1_pop = v.q1; r1_wdata = v.d1;
      #1;
      chk({tag, " gnt0"}, 32'(gnt0), 32'(v.g0));
      chk({tag, " gnt1"}, 32'(gnt1), 32'(v.g1));
      is_push = v.g0 ? v.p0 : v.g1 ? v.p1 : 1'b0;
      is_pop  = v.g0 ? v.q0 : v.g1 ? v.q1 : 1'b0;
      if (is_push && model.size() < 4) model.push_back(v.g1 ? v.d1 : v.d0);
      if (is_pop && model.size() > 0) exp_q.push_back({model.pop_back(), v.g1});
      @(posedge clk); #1;
      chk({tag, " count"}, 32'(count), 32'(v.cnt));
      chk({tag, " full"}, 32'(full), 32'(v.cnt == 4));
      chk({tag, " empty"}, 32'(empty), 32'(v.cnt == 0));
      chk({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
      chk({tag, " udf"}, 32'(udf), 32'(v.udf));
      check_rdata(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      {r0_push, r0_pop, r1_push, r1_pop} = '0;
      r0_wdata = '0; r1_wdata = '0;
      //        p0 q0 d0     p1 q1 d1     g0 g1 cnt ovf udf
      vecs.push_back(mk(1, 0, 8'h11, 0, 0, 8'h00, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 8'h22, 0, 0, 8'h00, 1, 0, 2, 0, 0));
      vecs.push_back(mk(1, 0, 8'h33, 0, 0, 8'h00, 1, 0, 3, 0, 0));
      vecs.push_back(mk(1, 0, 8'h44, 0, 0, 8'h00, 1, 0, 4, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h55, 0, 1, 4, 1, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 1, 3, 0, 0));
      vecs.push_back(mk(1, 0, 8'h44, 0, 0, 8'h00, 1, 0, 4, 0, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 3, 0, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 2, 0, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 8'hA1, 1, 0, 8'hB1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 8'hA2, 1, 0, 8'hB1, 0, 1, 2, 0, 0));
      vecs.push_back(mk(1, 0, 8'hA2, 1, 0, 8'hB2, 1, 0, 3, 0, 0));
      vecs.push_back(mk(1, 0, 8'hA3, 1, 0, 8'hB2, 0, 1, 4, 0, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0, 0, 8'h00, 1, 0, 3, 0, 0));
      vecs.push_back(mk(1, 1, 8'h00, 0, 1, 8'h00, 0, 1, 2, 0, 0));
      vecs.push_back(mk(1, 1, 8'h00, 0, 0, 8'h00, 0, 0, 2, 0, 0));
      vecs.push_back(mk(0, 1, 8'h00, 0, 1, 8'h00, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 8'h00, 1, 0, 8'h66, 0, 1, 2, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      chk("reset count", 32'(count), 0);
      chk("reset empty", 32'(empty), 1);
      chk("reset full", 32'(full), 0);
      chk("reset rvalid", 32'(rvalid), 0);
      chk("reset rdata", 32'(rdata), 0);
      chk("reset rid", 32'(rid), 0);
      chk("reset ovf", 32'(ovf), 0);
      chk("reset udf", 32'(udf), 0);
      chk("reset gnt", 32'({gnt0, gnt1}), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) step(vecs[i], i);

      // Pop lands, then reset is asserted mid-cycle while rvalid is high.
      {r0_push, r0_pop, r1_push, r1_pop} = 4'b0100;
      #1;
      chk("rst_pop gnt0", 32'(gnt0), 1);
      @(posedge clk); #1;
      chk("rst_pop rvalid", 32'(rvalid), 1);
      chk("rst_pop rdata", 32'(rdata), 32'h66);
      chk("rst_pop rid", 32'(rid), 0);
      chk("rst_pop count", 32'(count), 1);
      {r0_push, r0_pop} = 2'b00;
      #2 rst_n = 1'b0;
      #1;
      chk("async rvalid", 32'(rvalid), 0);
      chk("async count", 32'(count), 0);
      chk("async empty", 32'(empty), 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      {r0_push, r0_pop} = 2'b11;
      r0_wdata = 8'h77;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("illegal%0d gnt0", k), 32'(gnt0), 0);
         chk($sformatf("illegal%0d gnt1", k), 32'(gnt1), 0);
         @(posedge clk); #1;
         chk($sformatf("illegal%0d count", k), 32'(count), 0);
      end
      {r0_push, r0_pop} = 2'b00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
